modexp_ctrl: RTL and testbench



---
 rtl/modexp_pkg.sv | 24 ++
 rtl/modexp_div_port.sv | 79 +++++++
 rtl/modexp_ctrl.sv | 136 +++++++++++++
 tb/tb_modexp_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/modexp_pkg.sv
// Shared types and defaults for the modular-exponentiation sequencer.
// Both the top FSM and the divider port draw their states from state_t.
package modexp_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        REL   = 3'd3,
        CHK   = 3'd4,
        DONE  = 3'd5,
        ERR   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        RED = 2'd0,
        MUL = 2'd1,
        SQR = 2'd2
    } op_t;

    localparam int DEF_WIDTH       = 8;
    localparam int DEF_DIV_TIMEOUT = 40;

endpackage

// File: rtl/modexp_div_port.sv
// Handshake to the shared divider: ISSUE/WAIT/REL sequencing, timeout counting
// and capture of the remainder. One req pulse produces exactly one ack or timeout.
module modexp_div_port
    import modexp_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int DIV_TIMEOUT = DEF_DIV_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 ack,
    output logic                 timeout,
    output logic [WIDTH-1:0]     rem,
    output logic [2*WIDTH-1:0]   div_dividend,
    output logic [2*WIDTH-1:0]   div_divisor,
    output logic                 div_start,
    input  logic                 div_ready,
    input  logic [2*WIDTH-1:0]   div_remainder
);
    localparam int TW = $clog2(DIV_TIMEOUT + 1);

    state_t        ph;
    logic [TW-1:0] tmo;

    // Operands are below the modulus, so the high half is always zero.
    logic unused_rem_hi;
    assign unused_rem_hi = ^div_remainder[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            ph           <= IDLE;
            tmo          <= '0;
            ack          <= 1'b0;
            timeout      <= 1'b0;
            rem          <= '0;
            div_dividend <= '0;
            div_divisor  <= '0;
            div_start    <= 1'b0;
        end else begin
            ack     <= 1'b0;
            timeout <= 1'b0;
            case (ph)
                IDLE: if (req) begin
                    div_dividend <= dividend;
                    div_divisor  <= {{WIDTH{1'b0}}, divisor};
                    ph           <= ISSUE;
                end
                ISSUE: begin
                    // Operands were set up a cycle earlier, so they are stable at the start edge.
                    div_start <= 1'b1;
                    tmo       <= '0;
                    ph        <= WAIT;
                end
                WAIT: begin
                    if (div_ready) begin
                        rem       <= div_remainder[WIDTH-1:0];
                        div_start <= 1'b0;
                        ph        <= REL;
                    end else if (tmo == TW'(DIV_TIMEOUT)) begin
                        div_start <= 1'b0;
                        timeout   <= 1'b1;
                        ph        <= IDLE;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                REL: begin
                    ack <= 1'b1;
                    ph  <= IDLE;
                end
                default: ph <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/modexp_ctrl.sv
// Right-to-left square-and-multiply of base^exponent mod modulus, reducing every
// product through an external shared divider via modexp_div_port.
module modexp_ctrl
    import modexp_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int DIV_TIMEOUT = DEF_DIV_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go,
    input  logic [WIDTH-1:0]     base,
    input  logic [WIDTH-1:0]     exponent,
    input  logic [WIDTH-1:0]     modulus,
    output logic [WIDTH-1:0]     result,
    output logic                 done,
    output logic                 busy,
    output logic                 err,
    output logic [2*WIDTH-1:0]   div_dividend,
    output logic [2*WIDTH-1:0]   div_divisor,
    output logic                 div_start,
    input  logic                 div_ready,
    input  logic [2*WIDTH-1:0]   div_remainder
);
    state_t             state;
    op_t                ret;
    logic [WIDTH-1:0]   acc, b, e, m;
    logic               mul_done;
    logic               req;
    logic [2*WIDTH-1:0] dvd;
    logic               ack, timeout;
    logic [WIDTH-1:0]   rem;
    logic [2*WIDTH-1:0] prod_ab, prod_bb;

    assign prod_ab = {{WIDTH{1'b0}}, acc} * {{WIDTH{1'b0}}, b};
    assign prod_bb = {{WIDTH{1'b0}}, b} * {{WIDTH{1'b0}}, b};

    modexp_div_port #(.WIDTH(WIDTH), .DIV_TIMEOUT(DIV_TIMEOUT)) u_port (
        .clk(clk), .rst(rst), .req(req), .dividend(dvd), .divisor(m),
        .ack(ack), .timeout(timeout), .rem(rem),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_start(div_start), .div_ready(div_ready), .div_remainder(div_remainder)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ret      <= RED;
            acc      <= '0;
            b        <= '0;
            e        <= '0;
            m        <= '0;
            mul_done <= 1'b0;
            req      <= 1'b0;
            dvd      <= '0;
            result   <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            req  <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: if (go) begin
                    b        <= base;
                    e        <= exponent;
                    m        <= modulus;
                    err      <= 1'b0;
                    busy     <= 1'b1;
                    mul_done <= 1'b0;
                    if (modulus == '0) begin
                        state <= ERR;
                    end else begin
                        acc   <= (modulus == WIDTH'(1)) ? '0 : WIDTH'(1);
                        dvd   <= {{WIDTH{1'b0}}, base};
                        ret   <= RED;
                        req   <= 1'b1;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (timeout) begin
                        state <= ERR;
                    end else if (ack) begin
                        case (ret)
                            MUL: begin
                                acc      <= rem;
                                mul_done <= 1'b1;
                            end
                            SQR: begin
                                b        <= rem;
                                e        <= e >> 1;
                                mul_done <= 1'b0;
                            end
                            default: b <= rem;
                        endcase
                        state <= CHK;
                    end
                end
                CHK: begin
                    if (e == '0) begin
                        state <= DONE;
                    end else if (e[0] && !mul_done) begin
                        dvd   <= prod_ab;
                        ret   <= MUL;
                        req   <= 1'b1;
                        state <= WAIT;
                    end else if (e == WIDTH'(1)) begin
                        // Top bit already multiplied in; its square would be unused.
                        state <= DONE;
                    end else begin
                        dvd   <= prod_bb;
                        ret   <= SQR;
                        req   <= 1'b1;
                        state <= WAIT;
                    end
                end
                DONE: begin
                    result <= acc;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                ERR: begin
                    result <= '0;
                    err    <= 1'b1;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_modexp_ctrl.sv
// Randomized and directed checks of modexp_ctrl against a plain-arithmetic
// reference, with a behavioural divider of random latency.
module tb_modexp_ctrl;
    localparam int W   = 8;
    localparam int TMO = 40;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           go = 1'b0;
    logic [W-1:0]   base = '0, exponent = '0, modulus = '0;
    logic [W-1:0]   result;
    logic           done, busy, err;
    logic [2*W-1:0] div_dividend, div_divisor;
    logic           div_start;
    logic           div_ready = 1'b0;
    logic [2*W-1:0] div_remainder = '0;

    int  errors = 0;
    int  checks = 0;
    int  starts = 0;
    int  done_cnt = 0;
    bit  dead = 1'b0;
    logic prev_start = 1'b0;
    logic pending = 1'b0;
    int  lat_cnt = 0;

    always #5 clk = ~clk;

    modexp_ctrl #(.WIDTH(W), .DIV_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .go(go), .base(base), .exponent(exponent),
        .modulus(modulus), .result(result), .done(done), .busy(busy), .err(err),
        .div_dividend(div_dividend), .div_divisor(div_divisor), .div_start(div_start),
        .div_ready(div_ready), .div_remainder(div_remainder)
    );

    // Divider model: answers each rising div_start after a random delay.
    always @(posedge clk) begin
        div_ready  <= 1'b0;
        prev_start <= div_start;
        if (done) done_cnt <= done_cnt + 1;
        if (rst) begin
            pending <= 1'b0;
        end else if (div_start && !prev_start) begin
            starts <= starts + 1;
            if (!dead) begin
                pending <= 1'b1;
                lat_cnt <= int'($urandom_range(0, 6));
            end
        end else if (pending) begin
            if (lat_cnt == 0) begin
                div_ready     <= 1'b1;
                div_remainder <= (div_divisor == 0) ? '0 : div_dividend % div_divisor;
                pending       <= 1'b0;
            end else begin
                lat_cnt <= lat_cnt - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ref_modexp(input int bv, input int ev, input int mv);
        int r;
        if (mv == 0) return 0;
        r = 1 % mv;
        for (int i = 0; i < ev; i++) r = (r * (bv % mv)) % mv;
        return r;
    endfunction

    function automatic int ref_ops(input int ev);
        if (ev == 0) return 1;
        return $countones(ev) + $clog2(ev + 1);
    endfunction

    task automatic start_go(input int bv, input int ev, input int mv);
        @(negedge clk);
        base = W'(bv); exponent = W'(ev); modulus = W'(mv);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (cyc < limit) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_case(input string tag, input int bv, input int ev, input int mv);
        int s0, d0, cyc;
        bit ok;
        s0 = starts;
        d0 = done_cnt;
        start_go(bv, ev, mv);
        wait_done(2000, cyc, ok);
        chk({tag, "_done_seen"}, 32'(ok), 1);
        chk({tag, "_result"}, 32'(result), 32'(ref_modexp(bv, ev, mv)));
        chk({tag, "_err"}, 32'(err), 0);
        repeat (4) @(negedge clk);
        chk({tag, "_ops"}, 32'(starts - s0), 32'(ref_ops(ev)));
        chk({tag, "_done_pulses"}, 32'(done_cnt - d0), 1);
    endtask

    initial begin
        int cyc, s0, d0;
        bit ok;
        repeat (3) @(negedge clk);
        chk("rst_result", 32'(result), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_div_start", 32'(div_start), 0);
        chk("rst_div_dividend", 32'(div_dividend), 0);
        chk("rst_div_divisor", 32'(div_divisor), 0);
        rst = 1'b0;
        @(negedge clk);

        run_case("d3_5_7", 3, 5, 7);
        run_case("d2_10_11", 2, 10, 11);
        run_case("d200_1_13", 200, 1, 13);
        run_case("d5_0_13", 5, 0, 13);
        run_case("d5_0_1", 5, 0, 1);
        run_case("d255_255_255", 255, 255, 255);
        run_case("d7_3_1", 7, 3, 1);

        // Zero modulus: immediate error, divider untouched.
        s0 = starts;
        start_go(4, 3, 0);
        wait_done(3, cyc, ok);
        chk("m0_done_fast", 32'(ok), 1);
        chk("m0_err", 32'(err), 1);
        chk("m0_result", 32'(result), 0);
        chk("m0_no_start", 32'(starts - s0), 0);

        // Dead divider: timeout error.
        dead = 1'b1;
        s0 = starts;
        start_go(3, 5, 7);
        wait_done(TMO + 40, cyc, ok);
        chk("tmo_done_seen", 32'(ok), 1);
        chk("tmo_not_early", 32'(cyc >= TMO), 1);
        chk("tmo_err", 32'(err), 1);
        chk("tmo_result", 32'(result), 0);
        @(negedge clk);
        chk("tmo_start_low", 32'(div_start), 0);
        chk("tmo_one_start", 32'(starts - s0), 1);
        dead = 1'b0;

        // Next accepted go clears the sticky err.
        run_case("after_err", 3, 5, 7);

        // Reset during the second divider wait, then a clean restart.
        s0 = starts;
        start_go(3, 5, 7);
        cyc = 0;
        while (starts - s0 < 2 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        chk("midrst_reached", 32'(starts - s0 >= 2), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_start_low", 32'(div_start), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_result", 32'(result), 0);
        rst = 1'b0;
        @(negedge clk);
        run_case("restart", 3, 5, 7);

        // go while busy must be ignored.
        s0 = starts;
        d0 = done_cnt;
        start_go(3, 5, 7);
        repeat (3) @(negedge clk);
        chk("busy_high", 32'(busy), 1);
        start_go(9, 200, 250);
        wait_done(2000, cyc, ok);
        chk("gobusy_done_seen", 32'(ok), 1);
        chk("gobusy_result", 32'(result), 5);
        repeat (4) @(negedge clk);
        chk("gobusy_ops", 32'(starts - s0), 5);
        chk("gobusy_done_pulses", 32'(done_cnt - d0), 1);

        for (int i = 0; i < 25; i++) begin
            run_case($sformatf("rnd%0d", i), int'($urandom_range(0, 255)),
                     int'($urandom_range(0, 255)), int'($urandom_range(1, 255)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
